// File: rtl/rotary_pkg.sv
// Shared types and helpers for the rotary-joystick emulator: step directions,
// channel FSM states, analog-stick sector decode and one-hot rotations.
package rotary_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CCW  = 2'd1,
    CW   = 2'd2
  } rot_dir_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REPEAT = 1'b1
  } ch_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] sector;
  } sector_t;

  // |v| with -128 saturated to 127 so the result fits in 7 bits.
  function automatic logic [7:0] mag8(input logic signed [7:0] v);
    if (v == 8'sh80)
      return 8'd127;
    else if (v[7])
      return 8'(-v);
    else
      return v;
  endfunction

  function automatic sector_t sector8(input logic signed [7:0] x,
                                      input logic signed [7:0] y,
                                      input int unsigned       deadzone);
    logic [7:0] a;
    logic [7:0] b;
    sector_t    s;
    a = mag8(x);
    b = mag8(y);
    s.valid = (32'(a) >= deadzone) || (32'(b) >= deadzone);
    unique case ({x[7], y[7]})
      2'b00:   s.sector = (a > b)  ? 3'd0 : 3'd1;
      2'b10:   s.sector = (b >= a) ? 3'd2 : 3'd3;
      2'b11:   s.sector = (a > b)  ? 3'd4 : 3'd5;
      default: s.sector = (b >= a) ? 3'd6 : 3'd7;
    endcase
    return s;
  endfunction

  // Rotate the low n bits of a one-hot word; bits above n stay zero.
  function automatic logic [31:0] onehot_rotl(input logic [31:0] v, input int unsigned n);
    logic [63:0] w;
    logic [63:0] mask;
    w    = {32'd0, v};
    mask = (64'd1 << n) - 64'd1;
    w    = ((w << 1) | (w >> (n - 1))) & mask;
    return w[31:0];
  endfunction

  function automatic logic [31:0] onehot_rotr(input logic [31:0] v, input int unsigned n);
    logic [63:0] w;
    logic [63:0] mask;
    w    = {32'd0, v};
    mask = (64'd1 << n) - 64'd1;
    w    = ((w >> 1) | (w << (n - 1))) & mask;
    return w[31:0];
  endfunction

endpackage

// File: rtl/arcade_rotary_emu_if.sv
// Player-facing request/response bundle of the rotary emulator.
interface arcade_rotary_emu_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned POSITIONS   = 8
);
  localparam int unsigned PW = $clog2(POSITIONS);

  logic                           enable;
  logic                           speed_fast;
  logic [NUM_PLAYERS-1:0]         abs_mode;
  logic [NUM_PLAYERS-1:0]         ccw;
  logic [NUM_PLAYERS-1:0]         cw;
  logic [NUM_PLAYERS*8-1:0]       analog_x;
  logic [NUM_PLAYERS*8-1:0]       analog_y;
  logic [NUM_PLAYERS*POSITIONS-1:0] rotary_out;
  logic [NUM_PLAYERS*PW-1:0]      position;
  logic [NUM_PLAYERS-1:0]         step_pulse;

  modport master (
    output enable, speed_fast, abs_mode, ccw, cw, analog_x, analog_y,
    input  rotary_out, position, step_pulse
  );

  modport slave (
    input  enable, speed_fast, abs_mode, ccw, cw, analog_x, analog_y,
    output rotary_out, position, step_pulse
  );
endinterface

// File: rtl/rotary_channel.sv
// One player's rotary: immediate step on request, then auto-repeat, with
// optional absolute steering from an analog stick (adjacent steps only).
module rotary_channel
  import rotary_pkg::*;
#(
  parameter int unsigned POSITIONS  = 8,
  parameter int unsigned DIV_WIDTH  = 23,
  parameter int unsigned FAST_SHIFT = 2,
  parameter int unsigned ABS_EN     = 1,
  parameter int unsigned DEADZONE   = 16,
  localparam int unsigned PW        = $clog2(POSITIONS)
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 speed_fast,
  input  logic                 abs_mode,
  input  logic                 ccw,
  input  logic                 cw,
  input  logic signed [7:0]    analog_x,
  input  logic signed [7:0]    analog_y,
  output logic [POSITIONS-1:0] onehot,
  output logic [PW-1:0]        position,
  output logic                 step_pulse
);
  localparam int unsigned FAST_BITS = DIV_WIDTH - FAST_SHIFT;

  ch_state_t             state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [PW-1:0]         pos_q, pos_d;
  logic [POSITIONS-1:0]  oh_q, oh_d;
  logic                  step_q;
  logic                  do_step;
  rot_dir_t              rel_dir, abs_dir, dir;

  if (ABS_EN != 0) begin : g_abs
    sector_t    sec;
    logic [2:0] delta;
    // Shortest way round; a half-turn (delta 4) resolves to ccw.
    always_comb begin
      sec     = sector8(analog_x, analog_y, DEADZONE);
      delta   = sec.sector - 3'(pos_q);
      abs_dir = NONE;
      if (sec.valid && delta != 3'd0)
        abs_dir = (delta <= 3'd4) ? CCW : CW;
    end
  end else begin : g_no_abs
    assign abs_dir = NONE;
  end

  always_comb begin
    rel_dir = ccw ? CCW : (cw ? CW : NONE);
    dir     = (ABS_EN != 0 && abs_mode) ? abs_dir : rel_dir;
    cnt_inc = cnt_q + DIV_WIDTH'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    do_step = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dir != NONE) begin
          do_step = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end
      end
      REPEAT: begin
        cnt_d = cnt_inc;
        if (dir == NONE)
          state_d = IDLE;
        else if (speed_fast ? (cnt_inc[FAST_BITS-1:0] == '0) : (cnt_inc == '0))
          do_step = 1'b1;
      end
    endcase

    pos_d = pos_q;
    oh_d  = oh_q;
    if (do_step) begin
      if (dir == CCW) begin
        pos_d = (pos_q == PW'(POSITIONS - 1)) ? '0 : pos_q + PW'(1);
        oh_d  = POSITIONS'(onehot_rotl(32'(oh_q), POSITIONS));
      end else begin
        pos_d = (pos_q == '0) ? PW'(POSITIONS - 1) : pos_q - PW'(1);
        oh_d  = POSITIONS'(onehot_rotr(32'(oh_q), POSITIONS));
      end
    end

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      do_step = 1'b0;
      pos_d   = '0;
      oh_d    = POSITIONS'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      oh_q    <= POSITIONS'(1);
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      oh_q    <= oh_d;
      step_q  <= do_step;
    end
  end

  assign onehot     = oh_q;
  assign position   = pos_q;
  assign step_pulse = step_q;
endmodule

// File: rtl/arcade_rotary_emu.sv
// N-player rotary-joystick emulator: one rotary_channel per player plus the
// global enable override that blanks all outputs to the bootleg idle level.
module arcade_rotary_emu
  import rotary_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned POSITIONS   = 8,
  parameter int unsigned DIV_WIDTH   = 23,
  parameter int unsigned FAST_SHIFT  = 2,
  parameter int unsigned ABS_EN      = 1,
  parameter int unsigned DEADZONE    = 16
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  arcade_rotary_emu_if.slave bus
);
  localparam int unsigned PW = $clog2(POSITIONS);

  if (ABS_EN != 0 && POSITIONS != 8) begin : g_bad_cfg
    $error("arcade_rotary_emu: absolute mode needs POSITIONS == 8");
  end

  logic [POSITIONS-1:0] ch_oh   [NUM_PLAYERS];
  logic [PW-1:0]        ch_pos  [NUM_PLAYERS];
  logic                 ch_step [NUM_PLAYERS];
  logic                 en_q;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    rotary_channel #(
      .POSITIONS  (POSITIONS),
      .DIV_WIDTH  (DIV_WIDTH),
      .FAST_SHIFT (FAST_SHIFT),
      .ABS_EN     (ABS_EN),
      .DEADZONE   (DEADZONE)
    ) u_ch (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .enable     (bus.enable),
      .speed_fast (bus.speed_fast),
      .abs_mode   (bus.abs_mode[p]),
      .ccw        (bus.ccw[p]),
      .cw         (bus.cw[p]),
      .analog_x   (bus.analog_x[p*8 +: 8]),
      .analog_y   (bus.analog_y[p*8 +: 8]),
      .onehot     (ch_oh[p]),
      .position   (ch_pos[p]),
      .step_pulse (ch_step[p])
    );
  end

  // Registered copy of enable keeps the blanking aligned with the channel flops.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) en_q <= 1'b1;
    else          en_q <= bus.enable;
  end

  always_comb begin
    bus.rotary_out = '1;
    bus.position   = '0;
    bus.step_pulse = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      bus.rotary_out[p*POSITIONS +: POSITIONS] = en_q ? ch_oh[p] : '1;
      bus.position[p*PW +: PW]                 = ch_pos[p];
      bus.step_pulse[p]                        = ch_step[p];
    end
  end
endmodule

// File: tb/tb_arcade_rotary_emu.sv
// Scoreboard bench for arcade_rotary_emu: a behavioural model predicts every
// cycle's outputs, a monitor compares them against the DUT.
module tb_arcade_rotary_emu;
  localparam int NP   = 2;
  localparam int NPOS = 8;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  arcade_rotary_emu_if #(.NUM_PLAYERS(NP), .POSITIONS(NPOS)) bus ();

  arcade_rotary_emu #(
    .NUM_PLAYERS (NP),
    .POSITIONS   (NPOS),
    .DIV_WIDTH   (4),
    .FAST_SHIFT  (2),
    .ABS_EN      (1),
    .DEADZONE    (16)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // stimulus state
  bit       s_en;
  bit       s_fast;
  bit [1:0] s_abs, s_ccw, s_cw;
  int       s_x [NP];
  int       s_y [NP];

  // reference model state
  int m_pos  [NP];
  bit m_held [NP];
  int m_el   [NP];

  typedef struct packed {
    bit            en;
    bit [1:0][2:0] pos;
    bit [1:0]      pulse;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int target_of(input int x, input int y);
    int a, b;
    a = (x < 0) ? -x : x;
    b = (y < 0) ? -y : y;
    if (a > 127) a = 127;
    if (b > 127) b = 127;
    if (a < 16 && b < 16) return -1;
    if (x >= 0 && y >= 0) return (a > b) ? 0 : 1;
    if (x < 0 && y >= 0)  return (b >= a) ? 2 : 3;
    if (x < 0 && y < 0)   return (a > b) ? 4 : 5;
    return (b >= a) ? 6 : 7;
  endfunction

  // +1 = one position counter-clockwise, -1 = clockwise, 0 = stay
  function automatic int want_dir(input int p);
    int t, d;
    if (s_abs[p]) begin
      t = target_of(s_x[p], s_y[p]);
      if (t < 0) return 0;
      d = ((t - m_pos[p]) % 8 + 8) % 8;
      if (d == 0) return 0;
      return (d <= 4) ? 1 : -1;
    end
    return s_ccw[p] ? 1 : (s_cw[p] ? -1 : 0);
  endfunction

  task automatic drive_bus();
    bus.enable     = s_en;
    bus.speed_fast = s_fast;
    bus.abs_mode   = s_abs;
    bus.ccw        = s_ccw;
    bus.cw         = s_cw;
    for (int p = 0; p < NP; p++) begin
      bus.analog_x[p*8 +: 8] = 8'(s_x[p]);
      bus.analog_y[p*8 +: 8] = 8'(s_y[p]);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   dir, per;
    @(negedge clk_sys);
    drive_bus();
    e.en    = s_en;
    e.pulse = '0;
    per     = s_fast ? 4 : 16;
    for (int p = 0; p < NP; p++) begin
      if (!s_en) begin
        m_pos[p]  = 0;
        m_held[p] = 1'b0;
      end else begin
        dir = want_dir(p);
        if (!m_held[p]) begin
          if (dir != 0) begin
            m_pos[p]   = (m_pos[p] + dir + 8) % 8;
            e.pulse[p] = 1'b1;
            m_held[p]  = 1'b1;
            m_el[p]    = 0;
          end
        end else begin
          m_el[p]++;
          if (dir == 0)
            m_held[p] = 1'b0;
          else if (m_el[p] % per == 0) begin
            m_pos[p]   = (m_pos[p] + dir + 8) % 8;
            e.pulse[p] = 1'b1;
          end
        end
      end
      e.pos[p] = 3'(m_pos[p]);
    end
    sb_q.push_back(e);
    mon_on = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic idle_inputs();
    s_en = 1'b1; s_fast = 1'b0; s_abs = '0; s_ccw = '0; s_cw = '0;
    for (int p = 0; p < NP; p++) begin s_x[p] = 0; s_y[p] = 0; end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin m_pos[p] = 0; m_held[p] = 1'b0; m_el[p] = 0; end
  endtask

  function automatic int rand_axis();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 31)) - 16;
      1:       return -128;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  // monitor: one expected record per clock while the scoreboard is live
  always @(posedge clk_sys) begin
    #1;
    if (mon_on) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        for (int p = 0; p < NP; p++) begin
          chk($sformatf("step_pulse[%0d]", p), 32'(bus.step_pulse[p]), 32'(mon_e.pulse[p]));
          chk($sformatf("position[%0d]", p), 32'(bus.position[p*3 +: 3]),
              mon_e.en ? 32'(mon_e.pos[p]) : 32'd0);
          chk($sformatf("rotary_out[%0d]", p), 32'(bus.rotary_out[p*8 +: 8]),
              mon_e.en ? 32'(8'd1 << mon_e.pos[p]) : 32'hFF);
        end
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    drive_bus();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("reset_rotary", 32'(bus.rotary_out), 32'h0101);
    chk("reset_position", 32'(bus.position), 32'd0);
    chk("reset_pulse", 32'(bus.step_pulse), 32'd0);
    reset_n = 1'b1;

    // hold ccw: immediate step then one per 16 cycles
    s_ccw[0] = 1'b1; run(40);
    s_ccw[0] = 1'b0; run(20); settle();
    chk("ccw_hold_p0", 32'(bus.rotary_out[7:0]), 32'h08);

    // fast repeat: one step per 4 cycles
    s_fast = 1'b1; s_ccw[0] = 1'b1; run(9);
    s_ccw[0] = 1'b0; run(3); settle();
    chk("ccw_fast_p0", 32'(bus.rotary_out[7:0]), 32'h40);
    s_fast = 1'b0;

    // back to position 0 through enable, then cw pulse and ccw-priority
    s_en = 1'b0; run(3);
    s_en = 1'b1; run(2); settle();
    chk("reenable_rotary", 32'(bus.rotary_out), 32'h0101);
    s_cw[0] = 1'b1; run(1);
    s_cw[0] = 1'b0; run(3); settle();
    chk("cw_wrap_p0", 32'(bus.rotary_out[7:0]), 32'h80);
    s_ccw[0] = 1'b1; s_cw[0] = 1'b1; run(1);
    s_ccw[0] = 1'b0; s_cw[0] = 1'b0; run(3); settle();
    chk("ccw_wins_p0", 32'(bus.rotary_out[7:0]), 32'h01);

    // absolute mode on player 1
    s_abs[1] = 1'b1; s_x[1] = -100; s_y[1] = -10; run(60); settle();
    chk("abs_sector4_p1", 32'(bus.position[5:3]), 32'd4);
    s_x[1] = 5; s_y[1] = 3; run(20); settle();
    chk("abs_deadzone_p1", 32'(bus.position[5:3]), 32'd4);
    s_x[1] = 10; s_y[1] = 100; run(60); settle();
    chk("abs_sector1_p1", 32'(bus.rotary_out[15:8]), 32'h02);
    s_x[1] = 10; s_y[1] = -100; run(60); settle();
    chk("abs_d5_cw_p1", 32'(bus.rotary_out[15:8]), 32'h40);
    s_x[1] = -10; s_y[1] = 100; run(60); settle();
    chk("abs_d4_ccw_p1", 32'(bus.position[5:3]), 32'd2);

    // enable dropped mid-repeat
    s_abs = '0; s_ccw[0] = 1'b1; run(10);
    s_en = 1'b0; run(4); settle();
    chk("disabled_rotary", 32'(bus.rotary_out), 32'hFFFF);
    chk("disabled_pulse", 32'(bus.step_pulse), 32'd0);
    s_ccw[0] = 1'b0; s_en = 1'b1; run(2); settle();
    chk("enabled_rotary", 32'(bus.rotary_out), 32'h0101);

    // asynchronous reset between clock edges
    s_ccw[0] = 1'b1; s_ccw[1] = 1'b1; run(8); settle();
    mon_on = 1'b0;
    idle_inputs(); drive_bus();
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_rotary", 32'(bus.rotary_out), 32'h0101);
    chk("async_reset_position", 32'(bus.position), 32'd0);
    chk("async_reset_pulse", 32'(bus.step_pulse), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    model_reset();
    sb_q.delete();

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) s_en = 1'b0;
      else if (!s_en && $urandom_range(0, 7) == 0) s_en = 1'b1;
      if ($urandom_range(0, 63) == 0) s_fast = ~s_fast;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 19) == 0) s_ccw[p] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) s_cw[p]  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) == 0) s_abs[p] = ~s_abs[p];
        if ($urandom_range(0, 39) == 0) begin
          s_x[p] = rand_axis();
          s_y[p] = rand_axis();
        end
      end
      tick();
    end

    idle_inputs(); run(2); settle();
    mon_on = 1'b0;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arcade_rotary_emu.md
Name: arcade_rotary_emu

Overview:
Parametrised rotary-joystick emulator for arcade cores whose boards read an 8-way (or N-way) one-hot rotary switch per player. It is the generalised successor to the per-core inline rotary logic and adds three things: N players, an immediate step on press followed by auto-repeat, and an absolute mode that drives the rotary from an analog stick angle using adjacent steps only. It sits between `arcade_inputs`/`user_io` and the core's rotary input pins, in the `clk_sys` domain.

Parameters:
NUM_PLAYERS, 2, number of independent rotary channels
POSITIONS, 8, one-hot width per channel; absolute mode requires 8 (elaboration error otherwise when ABS_EN=1)
DIV_WIDTH, 23, normal repeat period = 2^DIV_WIDTH clk_sys cycles
FAST_SHIFT, 2, fast period = 2^(DIV_WIDTH-FAST_SHIFT) cycles
ABS_EN, 1, include absolute (analog) mode logic
DEADZONE, 16, analog magnitude below which the stick is treated as centred

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  0 = channel disabled (bootleg set): outputs forced all-ones
speed_fast  in  1  select fast repeat period
abs_mode  in  NUM_PLAYERS  per player: 1 = analog absolute mode, 0 = relative buttons
ccw  in  NUM_PLAYERS  relative rotate-left request (active high)
cw  in  NUM_PLAYERS  relative rotate-right request (active high)
analog_x  in  NUM_PLAYERS*8  signed stick X, +right
analog_y  in  NUM_PLAYERS*8  signed stick Y, +up
rotary_out  out  NUM_PLAYERS*POSITIONS  one-hot position per player (active high; core inverts)
position  out  NUM_PLAYERS*$clog2(POSITIONS)  binary index per player
step_pulse  out  NUM_PLAYERS  1-cycle strobe on each position change

Behaviour:
- Clocking and reset: one clock (`clk_sys`); reset is asynchronous and active-low (`reset_n`). Reset values: position=0, rotary_out=one-hot bit0 per channel (for example 8'h01), step_pulse=0, repeat counters=0, held flags=0.
- All outputs are registered. A position change appears on the cycle after the step decision, and step_pulse asserts in that same cycle.
- Step convention: ccw → pos+1 mod POSITIONS (one-hot shift left, bit MSB wraps to bit0). cw → pos-1 (bit0 wraps to MSB).
- Per-channel FSM, states IDLE and REPEAT:
  - IDLE: if the direction request (dir) is non-zero, step once immediately, clear the repeat counter, and go to REPEAT.
  - REPEAT: counter increments every cycle. When the counter's active bits are all zero (DIV_WIDTH bits normal, low DIV_WIDTH-FAST_SHIFT bits fast), step again. When dir becomes zero, return to IDLE with no step.
- Relative dir: ccw&cw → ccw wins. A change of direction while in REPEAT does not restart the counter; the next step uses the new direction.
- Absolute dir (abs_mode=1, ABS_EN=1): with a=|x|, b=|y| (|−128| saturates to 127), the target sector is:
  - x≥0,y≥0: a>b→0 else 1
  - x<0,y≥0: b≥a→2 else 3
  - x<0,y<0: a>b→4 else 5
  - x≥0,y<0: b≥a→6 else 7
  - a<DEADZONE and b<DEADZONE: no target, dir=0
  - d=(target−pos) mod 8: d=0 → dir=0; d=1..4 → ccw; d=5..7 → cw.
  - The same IDLE/REPEAT timing applies, so the position only ever moves by adjacent single steps.
- abs_mode toggled mid-repeat: the FSM continues and the direction is re-evaluated on each step.
- speed_fast change mid-repeat: takes effect at the next counter compare, with no extra step.
- enable=0: rotary_out = all ones, position held at 0, step_pulse=0, FSM forced to IDLE. On enable rising, resume from position 0 (rotary_out=one-hot bit0).
- reset_n asserted mid-step: immediate return to reset values; no pulse is emitted.
- Width rule: counters are exactly DIV_WIDTH bits and wrap naturally.

Decomposition:
- Package `rotary_pkg`: rot_dir_t enum (NONE, CCW, CW); function sector8(x,y,deadzone) returning a valid bit plus a 3-bit sector; function onehot_rotl/onehot_rotr.
- One sub-module, `rotary_channel`: a single player's FSM, counter and position. The top generates NUM_PLAYERS instances and handles the enable override.

Test Plan:
1. Bench parameters DIV_WIDTH=4, FAST_SHIFT=2. After reset → rotary_out = 16'h0101, position 0,0.
2. Hold ccw[0] for 40 cycles → first step at cycle+1 (8'h02), then steps every 16 cycles (8'h04, 8'h08). Releasing ccw[0] → no further step. With speed_fast=1, steps occur every 4 cycles.
3. From pos 0, pulse cw[0] for 1 cycle → 8'h80, step_pulse high for exactly 1 cycle. Assert ccw and cw together → ccw wins, rotary returns to 8'h01.
4. abs_mode[1]=1, pos=0, x=−100, y=−10 (sector 4) → steps to 1,2,3,4 as adjacent ccw steps spaced 16 cycles apart, then holds. Then x=5, y=3 (deadzone) → position holds.
5. abs_mode=1, pos=1, target 6 (d=5) → steps cw 1→0→7→6. Target with d=4 → steps ccw.
6. enable=0 mid-repeat → rotary_out=16'hFFFF and no pulses. enable=1 → 16'h0101. Assert reset_n=0 asynchronously mid-count → outputs reset immediately, without waiting for a clock edge.
